fork_join_ctrl: RTL
===================

# fork_join_ctrl

Synthesizable fork/join sequencer. It launches up to N_TASKS parallel worker blocks with one start pulse each, tracks their completion, and raises a single join pulse according to the selected join semantics: join-all, join-any or join-none. It sits between a control sequencer and a bank of worker engines. The sequencer's continuation step waits on `join_done` in the same way a procedural `fork ... join_any` hands control to the statement that follows it.

## Interface
- N_TASKS, 2, number of worker slots (1..32)
- CNT_W, 16, width of the elapsed-cycle counter
- ID_W, $clog2(N_TASKS) (minimum 1), width of task index
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  fork request, sampled only when `ready`=1
- mode  input  2  0=join-all, 1=join-any, 2=join-none, 3=reserved (treated as join-all)
- task_en  input  N_TASKS  mask of slots to launch, sampled with `start`
- task_done  input  N_TASKS  one-cycle completion pulse per worker
- ready  output  1  1 when state=IDLE and no task outstanding
- task_start  output  N_TASKS  one-cycle launch pulse per enabled slot
- pending  output  N_TASKS  outstanding task mask
- join_done  output  1  one-cycle pulse when the join condition is met
- first_id  output  ID_W  index of the completing task that satisfied join-any (lowest index on ties); 0 otherwise
- join_elapsed  output  CNT_W  cycles from launch to join, latched with `join_done`
- err  output  1  sticky; set when `task_done` arrives for a slot that is not pending

## Operation
- States: IDLE, LAUNCH, WAIT, JOIN.
- IDLE:
  - If `start` and `ready`: capture `mode` into mode_q, load `pending`←`task_en`, clear the elapsed counter, go to LAUNCH.
  - `start` while `ready`=0 is ignored. The request is dropped, not queued.
- LAUNCH (1 cycle): `task_start`=`task_en` captured value.
  - Next state is JOIN if mode_q=join-none or the captured mask is 0.
  - Otherwise next state is WAIT.
- WAIT: the elapsed counter increments each cycle and saturates at 2^CNT_W−1.
  - Join-all: go to JOIN on the cycle in which `pending` becomes 0.
  - Join-any: go to JOIN on the first cycle any pending bit receives `task_done`. That cycle sets `first_id`.
- JOIN (1 cycle):
  - `join_done`=1 and `join_elapsed` is updated.
  - Then go to IDLE. The sequencer continuation may proceed.
- Pending tracking is independent of state:
  - Each cycle, `pending` ← `pending` & ~`task_done` (from LAUNCH onward).
  - Tasks left running after join-any or join-none keep clearing their bits. `ready` stays 0 until `pending`=0.
- Error detection:
  - A `task_done` bit on a non-pending slot sets `err`. That bit is otherwise ignored.
  - `err` clears only on `rst`.
- Simultaneous completions in join-any: a single join only. All simultaneous bits clear. `first_id` = lowest set index.

## Timing
- `start` sampled at edge k → `task_start` high during cycle k+1 (LAUNCH).
- `task_done` sampled at edge m satisfies the join → `join_done` high during cycle m+1.
- A `task_done` pulse during the LAUNCH cycle is legal and counts.
- Join-none: `join_done` high in cycle k+2.
- `join_elapsed` = number of cycles from the LAUNCH cycle through the cycle containing the satisfying `task_done`, inclusive.
  - A done in the LAUNCH cycle gives 1.
- `ready` returns to 1 one cycle after JOIN if `pending`=0. Otherwise it returns to 1 the cycle after the last outstanding `task_done`.
- Reset values:
  - state=IDLE.
  - `ready`=1.
  - `task_start`, `pending`, `join_done`, `first_id`, `join_elapsed` and `err` all 0.
- `rst` mid-operation aborts the fork:
  - No `join_done` is issued and `task_start` drops.
  - `pending` is cleared.
  - Workers are not notified; they must be reset with the same `rst`.

## Test plan
- Join-any with 2 tasks (done at +20 and +30 cycles after LAUNCH):
  - `join_done` in cycle LAUNCH+21, `first_id`=0, `join_elapsed`=21.
  - `pending`=2'b10 until task 1 finishes; `ready` returns 1 cycle after LAUNCH+30.
- Join-all, same stimulus: `join_done` in cycle LAUNCH+31, `join_elapsed`=31, `ready`=1 the next cycle.
- Join-none, mask 2'b11:
  - `join_done` in cycle LAUNCH+1, `join_elapsed`=0.
  - `start` pulsed at LAUNCH+5 is ignored: no second `task_start`.
- Join-any, both `task_done` in the same cycle at +10: exactly one `join_done`, `first_id`=0, `pending`=0.
- Spurious `task_done`[1] with `task_en`=2'b01: `err`=1 and stays 1; the join completes normally on `task_done`[0].
- `rst` asserted at LAUNCH+5 of a join-all: no `join_done`; all outputs read reset values the next cycle.

Source files
------------

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches a masked set of worker slots with one start pulse
// each and issues a single join pulse under join-all, join-any or join-none rules.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; accepted only with no task outstanding
//   S_LAUNCH | task_start driven with the captured mask for one cycle
//   S_WAIT   | counting elapsed cycles until the join condition holds
//   S_JOIN   | join_done pulse, elapsed/first_id results visible
module fork_join_ctrl #(
    parameter int N_TASKS = 2,
    parameter int CNT_W   = 16,
    parameter int ID_W    = (N_TASKS > 1) ? $clog2(N_TASKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [N_TASKS-1:0] task_en,
    input  logic [N_TASKS-1:0] task_done,
    output logic               ready,
    output logic [N_TASKS-1:0] task_start,
    output logic [N_TASKS-1:0] pending,
    output logic               join_done,
    output logic [ID_W-1:0]    first_id,
    output logic [CNT_W-1:0]   join_elapsed,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_JOIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         mode_q;
    logic [N_TASKS-1:0] mask_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [N_TASKS-1:0] done_hit;
    logic [N_TASKS-1:0] pending_nxt;
    logic               mode_any;
    logic               mode_none;
    logic               accept;
    logic               launch_short;
    logic               join_hit;
    logic               enter_join;
    logic [ID_W-1:0]    low_id;

    assign mode_any     = (mode_q == 2'd1);
    assign mode_none    = (mode_q == 2'd2);
    assign done_hit     = task_done & pending;
    assign pending_nxt  = pending & ~task_done;
    assign accept       = (state == S_IDLE) && start && ready;
    // Join-none and empty forks join straight out of LAUNCH without timing anything.
    assign launch_short = (state == S_LAUNCH) && (mode_none || (mask_q == '0));
    // Mode 3 is reserved and behaves as join-all.
    assign join_hit     = mode_any ? (|done_hit) : (pending_nxt == '0);
    assign cnt_inc      = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign enter_join   = (state_nxt == S_JOIN) && (state != S_JOIN);

    always_comb begin
        low_id = '0;
        for (int i = N_TASKS - 1; i >= 0; i--) begin
            if (done_hit[i]) low_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = (launch_short || join_hit) ? S_JOIN : S_WAIT;
            S_WAIT:   if (join_hit) state_nxt = S_JOIN;
            S_JOIN:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == S_IDLE) && (pending == '0);
        task_start = (state == S_LAUNCH) ? mask_q : '0;
        join_done  = (state == S_JOIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 2'd0;
            mask_q       <= '0;
            pending      <= '0;
            cnt          <= '0;
            first_id     <= '0;
            join_elapsed <= '0;
            err          <= 1'b0;
        end else begin
            if (|(task_done & ~pending)) err <= 1'b1;
            if (accept) begin
                mode_q  <= mode;
                mask_q  <= task_en;
                pending <= task_en;
                cnt     <= '0;
            end else begin
                pending <= pending_nxt;
            end
            if (state == S_LAUNCH || state == S_WAIT) cnt <= cnt_inc;
            // Results land with the transition so they are visible alongside join_done.
            if (enter_join) begin
                join_elapsed <= launch_short ? '0 : cnt_inc;
                first_id     <= (mode_any && !launch_short) ? low_id : '0;
            end
        end
    end

endmodule
